tm1638_device_model: RTL and testbench
======================================

// Module: tm1638_device_model
// PURPOSE
//  Synthesizable TM1638 device-side responder: the other end of the LED&KEY SIO bus the board controller drives.
//  Decodes STB/CLK/DIO frames, holds 16-byte display RAM plus display-control state, and returns 4 key bytes on reads.
//  Used as an FPGA-resident board stand-in and as the DUT-side model for controller regressions.
// PARAMETERS
//  sync_stages  2  flops in each pin synchronizer (min 2)
// PORTS
//  clk           in   1    system clock; must be >= 8x sio_clk
//  rst           in   1    synchronous, active-high reset
//  sio_clk       in   1    bus clock from controller, idles high
//  sio_stb       in   1    frame strobe, active low
//  sio_data_in   in   1    DIO as seen on pin
//  sio_data_out  out  1    DIO driven during key read
//  sio_data_oe   out  1    1 = device drives DIO
//  key_bytes     in   32   key scan bytes; byte n = [8n+7:8n], sent n=0..3
//  disp_ram      out  128  display RAM; address a = [8a+7:8a]
//  disp_on       out  1    display-control on bit
//  disp_bright   out  3    display-control brightness
//  ram_wr        out  1    1-cycle pulse per RAM byte write
//  ram_wr_addr   out  4    address of that write (valid with ram_wr)
//  frame_end     out  1    1-cycle pulse on synced STB rising edge
//  proto_err     out  1    1-cycle pulse on illegal command/byte
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all outputs 0, disp_ram 0, mode=write/auto-inc, addr=0, state IDLE; reset mid-frame aborts it.
//  - Pins pass sync_stages flops; edges detected on synced values. Internal latency pin->action = sync_stages+1 clk.
//  - Bits LSB-first; DIO sampled on synced sio_clk rising edge; bit counter 0..7, byte completes on 8th rise.
//  - STB synced falling edge: bit cnt=0, state CMD. STB rising: frame_end pulse, partial byte discarded, oe=0, IDLE.
//  - CMD byte decode by [7:6]:
//    01 data cmd: mode_rd=b[1], fixed=b[2] (persist across frames). b[1]=1 -> RDATA; b[1]=0 -> IGNORE.
//    11 addr cmd: addr=b[3:0]; if mode_rd=0 -> WDATA else proto_err, IGNORE.
//    10 ctrl cmd: disp_on=b[3], disp_bright=b[2:0]; -> IGNORE.
//    00: proto_err, IGNORE.
//  - WDATA: each byte -> disp_ram[addr]=byte, ram_wr=1, ram_wr_addr=addr same cycle; addr+=1 mod 16 unless fixed (wrap 15->0).
//  - RDATA: key_bytes snapshot at cmd decode; byte idx 0..3. oe=1 from entry until STB rise.
//    data_out updates on each synced sio_clk falling edge with next bit (first fall -> byte0 bit0).
//    After byte 3 data_out=0, no error. Controller samples on rising edge; ratio rule guarantees setup.
//  - IGNORE: further full bytes in frame -> proto_err per byte; partial bytes silent.
//  - Simultaneous STB rise and 8th clk rise in same cycle: STB wins, byte discarded.
//  - Clk edges while STB high: ignored, no state change.
// STRUCTURE
//  - tm1638_pkg: opcode consts (CMD_DATA=2'b01, CMD_CTRL=2'b10, CMD_ADDR=2'b11), bit-position consts (RD=1, FIX=2, ON=3),
//    state enum {IDLE, CMD, WDATA, RDATA, IGNORE}.
//  - Sub-module tm1638_pin_sync: sync_stages flops + rise/fall pulses for one pin; three instances (clk, stb, dio).
//  - Top: FSM, shift register, bit/byte counters, addr/mode regs, 16x8 register RAM.
// TESTING
//  1 Frame 0x40; frame 0xC0 + 16 bytes 0x00..0x0F -> disp_ram[a]=a, 16 ram_wr pulses addr 0..15, no proto_err.
//  2 Frame 0x44; frame 0xC5,0x11,0x22 -> disp_ram[5]=0x22, others unchanged, 2 ram_wr both addr 5.
//  3 key_bytes=32'h10_01_00_11; frame 0x42 + 32 clks -> bench reads 0x11,0x00,0x01,0x10; oe=1 until STB rise.
//  4 Frame 0x8F -> disp_on=1,bright=7; frame 0x8A,0x55 -> disp_on=1,bright=2, one proto_err pulse.
//  5 Frame 0x40; 0xCE + 3 bytes -> writes addr 14,15,0; then STB rise after 5 bits of next byte -> no ram_wr, frame_end.
//  6 rst mid-RDATA byte 1 -> next cycle oe=0, disp_ram=0, mode auto/write; following 0x40/0xC0 frame works normally.

Source files
------------

// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared constants and types for the TM1638 device-side model.
//   Command opcodes (byte[7:6]), bit positions inside command bytes, FSM state enum.
package tm1638_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  // bit positions inside a command byte
  localparam int RD  = 1;  // data cmd: 1 = key read
  localparam int FIX = 2;  // data cmd: 1 = fixed address
  localparam int ON  = 3;  // ctrl cmd: display on

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;

endpackage

// File: rtl/tm1638_device_model_if.sv
// tm1638_device_model_if: the LED&KEY SIO pins.
//   master = board controller (drives clk/stb/dio), slave = TM1638 device.
//   sio_data_oe = 1 while the device owns DIO (key read).
interface tm1638_device_model_if;
  logic sio_clk;       // idles high
  logic sio_stb;       // active low frame strobe
  logic sio_data_in;   // DIO as seen on the pin
  logic sio_data_out;  // DIO value driven by the device
  logic sio_data_oe;   // device drive enable

  modport master (output sio_clk, sio_stb, sio_data_in,
                  input  sio_data_out, sio_data_oe);
  modport slave  (input  sio_clk, sio_stb, sio_data_in,
                  output sio_data_out, sio_data_oe);
endinterface

// File: rtl/tm1638_pin_sync.sv
// tm1638_pin_sync: multi-flop synchronizer for one asynchronous pin plus
// edge pulses taken from the synchronized value.
//   clk, rst     : system clock, synchronous active-high reset
//   pin          : asynchronous input
//   level        : synchronized level (sync_stages flops)
//   rise / fall  : 1-cycle pulses on synchronized edges
// RST_VAL matches the pin's idle level so reset release never fakes an edge.
module tm1638_pin_sync #(
  parameter int sync_stages = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [sync_stages-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {sync_stages{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], pin};
      prev_q <= sync_q[sync_stages-1];
    end
  end

  assign level = sync_q[sync_stages-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/tm1638_device_model.sv
// tm1638_device_model: TM1638 device-side responder on the SIO bus.
//   clk, rst     : system clock (>= 8x sio_clk), synchronous active-high reset
//   sio          : SIO pins (slave modport)
//   key_bytes    : key scan bytes, byte n = [8n+7:8n], returned n = 0..3
//   disp_ram     : 16-byte display RAM, address a = [8a+7:8a]
//   disp_on      : display-control on bit;  disp_bright : brightness
//   ram_wr       : 1-cycle pulse per RAM byte write, ram_wr_addr = its address
//   frame_end    : 1-cycle pulse on synced STB rising edge
//   proto_err    : 1-cycle pulse on an illegal command or unexpected byte
module tm1638_device_model
  import tm1638_pkg::*;
#(
  parameter int sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  tm1638_device_model_if.slave  sio,
  input  logic [31:0]           key_bytes,
  output logic [127:0]          disp_ram,
  output logic                  disp_on,
  output logic [2:0]            disp_bright,
  output logic                  ram_wr,
  output logic [3:0]            ram_wr_addr,
  output logic                  frame_end,
  output logic                  proto_err
);
  logic clk_lvl, clk_rise, clk_fall;
  logic stb_lvl, stb_rise, stb_fall;
  logic dio_lvl, dio_rise, dio_fall;

  tm1638_pin_sync #(.sync_stages(sync_stages), .RST_VAL(1'b1)) u_sync_clk (
    .clk(clk), .rst(rst), .pin(sio.sio_clk),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall));
  tm1638_pin_sync #(.sync_stages(sync_stages), .RST_VAL(1'b1)) u_sync_stb (
    .clk(clk), .rst(rst), .pin(sio.sio_stb),
    .level(stb_lvl), .rise(stb_rise), .fall(stb_fall));
  tm1638_pin_sync #(.sync_stages(sync_stages), .RST_VAL(1'b0)) u_sync_dio (
    .clk(clk), .rst(rst), .pin(sio.sio_data_in),
    .level(dio_lvl), .rise(dio_rise), .fall(dio_fall));

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [3:0]       addr;
  logic             mode_rd, fixed;
  logic [31:0]      key_snap;
  logic [5:0]       rd_cnt;     // next key bit to present; 32 = done
  logic             data_out_q, data_oe_q;
  logic [15:0][7:0] ram;
  logic [7:0]       byte_nxt;

  // LSB first: the new bit enters at the top, so after 8 rises bit0 sits at [0]
  assign byte_nxt = {dio_lvl, shreg[7:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      addr        <= '0;
      mode_rd     <= 1'b0;
      fixed       <= 1'b0;
      key_snap    <= '0;
      rd_cnt      <= '0;
      data_out_q  <= 1'b0;
      data_oe_q   <= 1'b0;
      ram         <= '0;
      disp_on     <= 1'b0;
      disp_bright <= '0;
      ram_wr      <= 1'b0;
      ram_wr_addr <= '0;
      frame_end   <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      ram_wr    <= 1'b0;
      frame_end <= 1'b0;
      proto_err <= 1'b0;
      if (stb_fall) begin
        state   <= CMD;
        bit_cnt <= '0;
      end else if (stb_rise) begin
        // STB wins over a coincident 8th clock rise: the byte is dropped
        state      <= IDLE;
        frame_end  <= 1'b1;
        bit_cnt    <= '0;
        data_oe_q  <= 1'b0;
        data_out_q <= 1'b0;
      end else if (state != IDLE && !stb_lvl) begin
        if (state == RDATA && clk_fall) begin
          if (!rd_cnt[5]) begin
            data_out_q <= key_snap[rd_cnt[4:0]];
            rd_cnt     <= rd_cnt + 6'd1;
          end else begin
            data_out_q <= 1'b0;
          end
        end
        if (clk_rise) begin
          shreg   <= byte_nxt;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              CMD: begin
                case (byte_nxt[7:6])
                  CMD_DATA: begin
                    mode_rd <= byte_nxt[RD];
                    fixed   <= byte_nxt[FIX];
                    if (byte_nxt[RD]) begin
                      state      <= RDATA;
                      key_snap   <= key_bytes;
                      rd_cnt     <= '0;
                      data_oe_q  <= 1'b1;
                      data_out_q <= 1'b0;
                    end else begin
                      state <= IGNORE;
                    end
                  end
                  CMD_ADDR: begin
                    addr <= byte_nxt[3:0];
                    if (!mode_rd) begin
                      state <= WDATA;
                    end else begin
                      state     <= IGNORE;
                      proto_err <= 1'b1;
                    end
                  end
                  CMD_CTRL: begin
                    disp_on     <= byte_nxt[ON];
                    disp_bright <= byte_nxt[2:0];
                    state       <= IGNORE;
                  end
                  default: begin
                    state     <= IGNORE;
                    proto_err <= 1'b1;
                  end
                endcase
              end
              WDATA: begin
                ram[addr]   <= byte_nxt;
                ram_wr      <= 1'b1;
                ram_wr_addr <= addr;
                if (!fixed) addr <= addr + 4'd1;
              end
              IGNORE:  proto_err <= 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign disp_ram         = ram;
  assign sio.sio_data_out = data_out_q;
  assign sio.sio_data_oe  = data_oe_q;

  logic unused_pins;
  assign unused_pins = &{1'b0, clk_lvl, dio_rise, dio_fall, shreg[0]};
endmodule

// File: tb/tb_tm1638_device_model.sv
// Bench for tm1638_device_model: directed scenarios plus randomized frames,
// checked against a frame-level reference model of the device.
module tb_tm1638_device_model;
  localparam int HALF = 8;  // clk cycles per sio_clk phase

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  key_bytes;
  logic [127:0] disp_ram;
  logic         disp_on;
  logic [2:0]   disp_bright;
  logic         ram_wr;
  logic [3:0]   ram_wr_addr;
  logic         frame_end;
  logic         proto_err;

  tm1638_device_model_if sio();

  tm1638_device_model #(.sync_stages(2)) dut (
    .clk(clk), .rst(rst), .sio(sio), .key_bytes(key_bytes),
    .disp_ram(disp_ram), .disp_on(disp_on), .disp_bright(disp_bright),
    .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr),
    .frame_end(frame_end), .proto_err(proto_err));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [7:0] m_ram [16];
  logic       m_on, m_rd, m_fix;
  logic [2:0] m_bright;
  int         m_err = 0, m_fe = 0;
  int         exp_wr[$];

  // observed pulses
  int got_wr[$];
  int n_err = 0, n_fe = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wr)    got_wr.push_back(int'(ram_wr_addr));
      if (proto_err) n_err++;
      if (frame_end) n_fe++;
    end
  end

  function automatic logic [127:0] m_pack();
    logic [127:0] r;
    for (int a = 0; a < 16; a++) r[8*a +: 8] = m_ram[a];
    return r;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 16; a++) m_ram[a] = 8'h00;
    m_on = 1'b0; m_bright = 3'd0; m_rd = 1'b0; m_fix = 1'b0;
  endtask

  // Whole-frame effect: first byte is the command, the rest are data bytes.
  task automatic model_frame(input logic [7:0] q[$]);
    logic [7:0] c;
    int a;
    m_fe++;
    if (q.size() == 0) return;
    c = q[0];
    case (c[7:6])
      2'b01: begin m_rd = c[1]; m_fix = c[2]; m_err += q.size() - 1; end
      2'b10: begin m_on = c[3]; m_bright = c[2:0]; m_err += q.size() - 1; end
      2'b11: begin
        if (m_rd) m_err += q.size();
        else begin
          a = int'(c[3:0]);
          for (int i = 1; i < q.size(); i++) begin
            m_ram[a] = q[i];
            exp_wr.push_back(a);
            if (!m_fix) a = (a + 1) % 16;
          end
        end
      end
      default: m_err += q.size();
    endcase
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sio.sio_clk = 1'b0; sio.sio_data_in = b;
    ticks(HALF);
    sio.sio_clk = 1'b1;
    ticks(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_cnt"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      chk({tag, ".wr_addr"}, got_wr[i], exp_wr[i]);
    chk({tag, ".perr"}, n_err, m_err);
    chk({tag, ".frame_end"}, n_fe, m_fe);
    chk({tag, ".ram"}, disp_ram, m_pack());
    chk({tag, ".ctrl"}, {disp_on, disp_bright}, {m_on, m_bright});
    chk({tag, ".oe_idle"}, sio.sio_data_oe, 1'b0);
    got_wr.delete();
    exp_wr.delete();
  endtask

  // Write-direction frame: whole bytes, then `part` stray bits before STB rises.
  task automatic frame(input string tag, input logic [7:0] q[$], input int part);
    sio.sio_stb = 1'b0;
    ticks(HALF);
    foreach (q[i]) send_byte(q[i]);
    for (int i = 0; i < part; i++) send_bit(1'($urandom_range(1)));
    sio.sio_stb = 1'b1;
    ticks(2 * HALF + 4);
    model_frame(q);
    check_all(tag);
  endtask

  // Key read: command then nbytes clocked out by the controller.
  task automatic rd_frame(input string tag, input logic [7:0] cmd, input logic [31:0] keys,
                          input int nbytes);
    logic [7:0] rb, q[$];
    logic       oe_all;
    key_bytes = keys;
    sio.sio_data_in = 1'b1;
    sio.sio_stb = 1'b0;
    ticks(HALF);
    send_byte(cmd);
    oe_all = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      rb = 8'h00;
      for (int i = 0; i < 8; i++) begin
        sio.sio_clk = 1'b0;
        ticks(HALF);
        rb[i] = sio.sio_data_out;
        oe_all &= sio.sio_data_oe;
        sio.sio_clk = 1'b1;
        ticks(HALF);
      end
      chk({tag, ".key"}, rb, (k < 4) ? keys[8*k +: 8] : 8'h00);
    end
    chk({tag, ".oe_busy"}, oe_all, 1'b1);
    sio.sio_stb = 1'b1;
    ticks(2 * HALF + 4);
    q.push_back(cmd);
    model_frame(q);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] c;
    int         kind;
    logic [31:0] keys;

    rst = 1'b1;
    key_bytes = '0;
    sio.sio_clk = 1'b1; sio.sio_stb = 1'b1; sio.sio_data_in = 1'b1;
    model_reset();
    ticks(3);
    rst = 1'b0;
    ticks(1);
    chk("reset.ram", disp_ram, 128'd0);
    chk("reset.ctrl", {disp_on, disp_bright}, 4'd0);
    chk("reset.oe", {sio.sio_data_oe, sio.sio_data_out}, 2'd0);
    chk("reset.pulses", {ram_wr, frame_end, proto_err}, 3'd0);

    // 1: auto-increment fill of all 16 bytes
    q = {}; q.push_back(8'h40); frame("t1a", q, 0);
    q = {}; q.push_back(8'hC0);
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    frame("t1b", q, 0);

    // 2: fixed address
    q = {}; q.push_back(8'h44); frame("t2a", q, 0);
    q = {}; q.push_back(8'hC5); q.push_back(8'h11); q.push_back(8'h22); frame("t2b", q, 0);

    // 3: key read, fifth byte must be zero
    rd_frame("t3", 8'h42, 32'h10_01_00_11, 5);

    // 4: display control, stray byte after ctrl cmd
    q = {}; q.push_back(8'h8F); frame("t4a", q, 0);
    q = {}; q.push_back(8'h8A); q.push_back(8'h55); frame("t4b", q, 0);

    // 5: wrap 15->0, partial byte dropped
    q = {}; q.push_back(8'h40); frame("t5a", q, 0);
    q = {}; q.push_back(8'hCE); q.push_back(8'hA1); q.push_back(8'hB2); q.push_back(8'hC3);
    frame("t5b", q, 5);

    // 6: reset in the middle of key byte 1
    keys = $urandom;
    key_bytes = keys;
    sio.sio_stb = 1'b0;
    ticks(HALF);
    send_byte(8'h42);
    for (int i = 0; i < 11; i++) begin
      sio.sio_clk = 1'b0; ticks(HALF);
      sio.sio_clk = 1'b1; ticks(HALF);
    end
    rst = 1'b1;
    sio.sio_stb = 1'b1;
    ticks(1);
    chk("t6.oe", sio.sio_data_oe, 1'b0);
    chk("t6.ram", disp_ram, 128'd0);
    chk("t6.ctrl", {disp_on, disp_bright}, 4'd0);
    rst = 1'b0;
    model_reset();
    ticks(2 * HALF);
    // no data cmd first: write mode and auto-increment must be the reset state
    q = {}; q.push_back(8'hC3); q.push_back(8'h5A); q.push_back(8'hA5); frame("t6a", q, 0);
    q = {}; q.push_back(8'h40); frame("t6b", q, 0);
    q = {}; q.push_back(8'hC0); q.push_back(8'h77); frame("t6c", q, 0);

    // randomized frames
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(5);
      q = {};
      case (kind)
        0: begin
          c = 8'h40 | (8'($urandom) & 8'h3D);
          q.push_back(c);
          for (int i = $urandom_range(2); i > 0; i--) q.push_back(8'($urandom));
          frame("rnd_data", q, $urandom_range(7));
        end
        1, 2: begin
          q.push_back(8'hC0 | 8'($urandom_range(15)));
          for (int i = $urandom_range(5); i > 0; i--) q.push_back(8'($urandom));
          frame("rnd_addr", q, $urandom_range(7));
        end
        3: begin
          q.push_back(8'h80 | (8'($urandom) & 8'h3F));
          for (int i = $urandom_range(1); i > 0; i--) q.push_back(8'($urandom));
          frame("rnd_ctrl", q, 0);
        end
        4: begin
          q.push_back(8'($urandom_range(63)));
          for (int i = $urandom_range(2); i > 0; i--) q.push_back(8'($urandom));
          frame("rnd_bad", q, $urandom_range(7));
        end
        default: begin
          c = 8'h42 | (8'($urandom) & 8'h04);
          rd_frame("rnd_read", c, $urandom, $urandom_range(1, 5));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
